// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetcher
// Purpose : Instruction-fetch front end; holds the PC, pushes icache hits into
//           the instruction queue and services misses through the memory port.
// Rev     : 1.0  initial release
// ============================================================================
module inst_fetcher #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic [ADDR_WIDTH-1:0] if_to_ic_fetch_addr,
  input  logic                  ic_to_if_hit,
  input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
  output logic [ADDR_WIDTH-1:0] if_to_ic_update_addr,
  output logic [INST_WIDTH-1:0] if_to_ic_inst,
  output logic                  if_to_ic_inst_valid,
  output logic                  if_to_mc_req,
  output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
  input  logic                  mc_to_if_done,
  input  logic [INST_WIDTH-1:0] mc_to_if_data,
  input  logic                  iq_full,
  output logic                  if_to_iq_valid,
  output logic [INST_WIDTH-1:0] if_to_iq_inst,
  output logic [ADDR_WIDTH-1:0] if_to_iq_pc,
  input  logic                  br_redirect,
  input  logic [ADDR_WIDTH-1:0] br_target
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mc_req_q, mc_req_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
  logic [ADDR_WIDTH-1:0] ic_upd_addr_q, ic_upd_addr_d;
  logic [INST_WIDTH-1:0] ic_inst_q, ic_inst_d;
  logic                  ic_inst_valid_q, ic_inst_valid_d;
  logic                  iq_valid_q, iq_valid_d;
  logic [INST_WIDTH-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_WIDTH-1:0] iq_pc_q, iq_pc_d;

  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_fill_fwd;
  logic                  w_hit;
  logic [INST_WIDTH-1:0] w_hit_inst;
  logic                  w_fill;

  assign w_target = br_target & c_align_mask;

  // The icache only absorbs the fill one edge after we strobe it, so forward
  // the fill word ourselves to avoid re-missing on the same address.
  assign w_fill_fwd = ic_inst_valid_q && (ic_upd_addr_q == pc_q);
  assign w_hit      = ic_to_if_hit || w_fill_fwd;
  assign w_hit_inst = ic_to_if_hit ? ic_to_if_hit_inst : ic_inst_q;

  assign w_fill = (state_q != S_FETCH) && mc_to_if_done;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    mc_req_d        = mc_req_q;
    mc_addr_d       = mc_addr_q;
    ic_upd_addr_d   = ic_upd_addr_q;
    ic_inst_d       = ic_inst_q;
    ic_inst_valid_d = 1'b0;
    iq_valid_d      = 1'b0;
    iq_inst_d       = iq_inst_q;
    iq_pc_d         = iq_pc_q;

    case (state_q)
      S_FETCH: begin
        if (br_redirect) begin
          pc_d = w_target;
        end else if (w_hit) begin
          if (!iq_full) begin
            iq_valid_d = 1'b1;
            iq_inst_d  = w_hit_inst;
            iq_pc_d    = pc_q;
            pc_d       = pc_q + c_pc_step;
          end
        end else begin
          mc_req_d  = 1'b1;
          mc_addr_d = pc_q;
          state_d   = S_MISS;
        end
      end
      S_MISS: begin
        if (mc_to_if_done) begin
          state_d = S_FETCH;
        end else if (br_redirect) begin
          state_d = S_DROP;
        end
        if (br_redirect) begin
          pc_d = w_target;
        end
      end
      S_DROP: begin
        if (mc_to_if_done) begin
          state_d = S_FETCH;
        end
        if (br_redirect) begin
          pc_d = w_target;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A returned word is valid for its address even when its miss was cancelled.
    if (w_fill) begin
      mc_req_d        = 1'b0;
      ic_upd_addr_d   = mc_addr_q;
      ic_inst_d       = mc_to_if_data;
      ic_inst_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      mc_req_q        <= 1'b0;
      mc_addr_q       <= '0;
      ic_upd_addr_q   <= '0;
      ic_inst_q       <= '0;
      ic_inst_valid_q <= 1'b0;
      iq_valid_q      <= 1'b0;
      iq_inst_q       <= '0;
      iq_pc_q         <= '0;
    end else if (rdy_in) begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      mc_req_q        <= mc_req_d;
      mc_addr_q       <= mc_addr_d;
      ic_upd_addr_q   <= ic_upd_addr_d;
      ic_inst_q       <= ic_inst_d;
      ic_inst_valid_q <= ic_inst_valid_d;
      iq_valid_q      <= iq_valid_d;
      iq_inst_q       <= iq_inst_d;
      iq_pc_q         <= iq_pc_d;
    end
  end

  assign if_to_ic_fetch_addr  = pc_q;
  assign if_to_ic_update_addr = ic_upd_addr_q;
  assign if_to_ic_inst        = ic_inst_q;
  assign if_to_ic_inst_valid  = ic_inst_valid_q;
  assign if_to_mc_req         = mc_req_q;
  assign if_to_mc_addr        = mc_addr_q;
  assign if_to_iq_valid       = iq_valid_q;
  assign if_to_iq_inst        = iq_inst_q;
  assign if_to_iq_pc          = iq_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetcher
// Purpose : Directed self-checking bench for inst_fetcher with a small icache.
// Rev     : 1.0  initial release
// ============================================================================
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] if_to_ic_fetch_addr;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_hit_inst;
  logic [31:0] if_to_ic_update_addr;
  logic [31:0] if_to_ic_inst;
  logic        if_to_ic_inst_valid;
  logic        if_to_mc_req;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_data;
  logic        iq_full;
  logic        if_to_iq_valid;
  logic [31:0] if_to_iq_inst;
  logic [31:0] if_to_iq_pc;
  logic        br_redirect;
  logic [31:0] br_target;

  int n_vec = 0;
  int n_err = 0;

  inst_fetcher #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0)
  ) u_dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .if_to_ic_fetch_addr  (if_to_ic_fetch_addr),
    .ic_to_if_hit         (ic_to_if_hit),
    .ic_to_if_hit_inst    (ic_to_if_hit_inst),
    .if_to_ic_update_addr (if_to_ic_update_addr),
    .if_to_ic_inst        (if_to_ic_inst),
    .if_to_ic_inst_valid  (if_to_ic_inst_valid),
    .if_to_mc_req         (if_to_mc_req),
    .if_to_mc_addr        (if_to_mc_addr),
    .mc_to_if_done        (mc_to_if_done),
    .mc_to_if_data        (mc_to_if_data),
    .iq_full              (iq_full),
    .if_to_iq_valid       (if_to_iq_valid),
    .if_to_iq_inst        (if_to_iq_inst),
    .if_to_iq_pc          (if_to_iq_pc),
    .br_redirect          (br_redirect),
    .br_target            (br_target)
  );

  always #5 clk_in = ~clk_in;

  // Direct-mapped icache model, 256 words, full-address tags, write on fill.
  logic        cache_init;
  logic        ic_v   [256];
  logic [31:0] ic_tag [256];
  logic [31:0] ic_dat [256];
  logic [7:0]  w_idx;
  logic [7:0]  w_upd_idx;

  assign w_idx             = if_to_ic_fetch_addr[9:2];
  assign w_upd_idx         = if_to_ic_update_addr[9:2];
  assign ic_to_if_hit      = ic_v[w_idx] && (ic_tag[w_idx] == if_to_ic_fetch_addr);
  assign ic_to_if_hit_inst = ic_dat[w_idx];

  always @(posedge clk_in) begin
    if (cache_init) begin
      for (int i = 0; i < 256; i++) ic_v[i] <= 1'b0;
      for (int a = 4; a <= 60; a += 4) begin
        ic_v[a/4]   <= 1'b1;
        ic_tag[a/4] <= 32'(a);
        ic_dat[a/4] <= 32'hA000_0000 | 32'(a);
      end
      ic_v[64]  <= 1'b1; ic_tag[64]  <= 32'h0000_0100; ic_dat[64]  <= 32'hB000_0100;
      ic_v[65]  <= 1'b1; ic_tag[65]  <= 32'h0000_0104; ic_dat[65]  <= 32'hB000_0104;
      ic_v[255] <= 1'b1; ic_tag[255] <= 32'hFFFF_FFFC; ic_dat[255] <= 32'hC0FF_EE00;
    end else if (rdy_in && if_to_ic_inst_valid) begin
      ic_v[w_upd_idx]   <= 1'b1;
      ic_tag[w_upd_idx] <= if_to_ic_update_addr;
      ic_dat[w_upd_idx] <= if_to_ic_inst;
    end
  end

  // Queue-side push log: a push is accepted only on a ready, non-reset edge.
  logic        r_rdy_edge = 1'b0;
  logic [31:0] plog [256];
  int          pcount = 0;

  always @(posedge clk_in) r_rdy_edge <= rdy_in && !rst_in;

  always @(negedge clk_in) begin
    if (if_to_iq_valid && r_rdy_edge && !rst_in && pcount < 256) begin
      plog[pcount] = if_to_iq_pc;
      pcount       = pcount + 1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    cache_init    = 1'b1;
    mc_to_if_done = 1'b0;
    mc_to_if_data = '0;
    iq_full       = 1'b0;
    br_redirect   = 1'b0;
    br_target     = '0;
    step();
    step();
    check_vec("rst_fetch_addr", if_to_ic_fetch_addr, 32'h0);
    check_vec("rst_mc_req", {31'b0, if_to_mc_req}, 32'h0);
    check_vec("rst_iq_valid", {31'b0, if_to_iq_valid}, 32'h0);
    check_vec("rst_fill_valid", {31'b0, if_to_ic_inst_valid}, 32'h0);
    rst_in     = 1'b0;
    cache_init = 1'b0;

    // Cold miss at 0x0
    check_vec("t1_fetch_addr", if_to_ic_fetch_addr, 32'h0);
    step();
    check_vec("t1_mc_req", {31'b0, if_to_mc_req}, 32'h1);
    check_vec("t1_mc_addr", if_to_mc_addr, 32'h0);
    step();
    step();
    check_vec("t1_mc_req_held", {31'b0, if_to_mc_req}, 32'h1);
    check_vec("t1_no_push_miss", {31'b0, if_to_iq_valid}, 32'h0);
    mc_to_if_done = 1'b1;
    mc_to_if_data = 32'h0010_0093;
    step();
    mc_to_if_done = 1'b0;
    check_vec("t1_fill_valid", {31'b0, if_to_ic_inst_valid}, 32'h1);
    check_vec("t1_fill_addr", if_to_ic_update_addr, 32'h0);
    check_vec("t1_fill_inst", if_to_ic_inst, 32'h0010_0093);
    check_vec("t1_mc_req_drop", {31'b0, if_to_mc_req}, 32'h0);
    step();
    check_vec("t1_push_valid", {31'b0, if_to_iq_valid}, 32'h1);
    check_vec("t1_push_inst", if_to_iq_inst, 32'h0010_0093);
    check_vec("t1_push_pc", if_to_iq_pc, 32'h0);

    // Warm stream 0x4, 0x8, 0xC
    for (int k = 1; k <= 3; k++) begin
      step();
      check_vec("t2_push_valid", {31'b0, if_to_iq_valid}, 32'h1);
      check_vec("t2_push_pc", if_to_iq_pc, 32'(4 * k));
      check_vec("t2_push_inst", if_to_iq_inst, 32'hA000_0000 | 32'(4 * k));
      check_vec("t2_no_req", {31'b0, if_to_mc_req}, 32'h0);
    end

    // Queue back-pressure at 0x8
    br_redirect = 1'b1;
    br_target   = 32'h8;
    step();
    br_redirect = 1'b0;
    check_vec("t3_redir_no_push", {31'b0, if_to_iq_valid}, 32'h0);
    iq_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_vec("t3_full_no_push", {31'b0, if_to_iq_valid}, 32'h0);
      check_vec("t3_full_pc", if_to_ic_fetch_addr, 32'h8);
      check_vec("t3_full_no_req", {31'b0, if_to_mc_req}, 32'h0);
    end
    iq_full = 1'b0;
    step();
    check_vec("t3_push_valid", {31'b0, if_to_iq_valid}, 32'h1);
    check_vec("t3_push_pc", if_to_iq_pc, 32'h8);

    // Redirect during a miss
    br_redirect = 1'b1;
    br_target   = 32'h200;
    step();
    br_redirect = 1'b0;
    step();
    check_vec("t4_mc_req", {31'b0, if_to_mc_req}, 32'h1);
    check_vec("t4_mc_addr", if_to_mc_addr, 32'h200);
    br_redirect = 1'b1;
    br_target   = 32'h103;
    step();
    br_redirect = 1'b0;
    check_vec("t4_pc_aligned", if_to_ic_fetch_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      check_vec("t4_drop_req", {31'b0, if_to_mc_req}, 32'h1);
      check_vec("t4_drop_addr", if_to_mc_addr, 32'h200);
      check_vec("t4_drop_no_push", {31'b0, if_to_iq_valid}, 32'h0);
      step();
    end
    mc_to_if_done = 1'b1;
    mc_to_if_data = 32'hDEAD_0200;
    step();
    mc_to_if_done = 1'b0;
    check_vec("t4_fill_valid", {31'b0, if_to_ic_inst_valid}, 32'h1);
    check_vec("t4_fill_addr", if_to_ic_update_addr, 32'h200);
    check_vec("t4_fill_inst", if_to_ic_inst, 32'hDEAD_0200);
    check_vec("t4_fill_no_push", {31'b0, if_to_iq_valid}, 32'h0);
    check_vec("t4_req_low", {31'b0, if_to_mc_req}, 32'h0);
    check_vec("t4_fetch_target", if_to_ic_fetch_addr, 32'h100);
    step();
    check_vec("t4_push_pc", if_to_iq_pc, 32'h100);
    check_vec("t4_push_inst", if_to_iq_inst, 32'hB000_0100);

    // Redirect coincident with done
    br_redirect = 1'b1;
    br_target   = 32'h300;
    step();
    br_redirect = 1'b0;
    check_vec("t5_redir_no_push", {31'b0, if_to_iq_valid}, 32'h0);
    step();
    check_vec("t5_mc_addr", if_to_mc_addr, 32'h300);
    step();
    mc_to_if_done = 1'b1;
    mc_to_if_data = 32'hCAFE_0300;
    br_redirect   = 1'b1;
    br_target     = 32'h10;
    step();
    mc_to_if_done = 1'b0;
    br_redirect   = 1'b0;
    check_vec("t5_fill_valid", {31'b0, if_to_ic_inst_valid}, 32'h1);
    check_vec("t5_fill_addr", if_to_ic_update_addr, 32'h300);
    check_vec("t5_fill_inst", if_to_ic_inst, 32'hCAFE_0300);
    check_vec("t5_req_low", {31'b0, if_to_mc_req}, 32'h0);
    check_vec("t5_pc_target", if_to_ic_fetch_addr, 32'h10);
    check_vec("t5_no_stale_push", {31'b0, if_to_iq_valid}, 32'h0);
    step();
    check_vec("t5_push_pc", if_to_iq_pc, 32'h10);
    check_vec("t5_push_inst", if_to_iq_inst, 32'hA000_0010);

    // Asynchronous reset during a miss
    br_redirect = 1'b1;
    br_target   = 32'h400;
    step();
    br_redirect = 1'b0;
    step();
    check_vec("t6_mc_req", {31'b0, if_to_mc_req}, 32'h1);
    #1 rst_in = 1'b1;
    #1;
    check_vec("t6_async_req", {31'b0, if_to_mc_req}, 32'h0);
    check_vec("t6_async_addr", if_to_mc_addr, 32'h0);
    check_vec("t6_async_pc", if_to_ic_fetch_addr, 32'h0);
    check_vec("t6_async_iqpc", if_to_iq_pc, 32'h0);
    check_vec("t6_async_fill", if_to_ic_update_addr, 32'h0);
    step();
    step();
    rst_in = 1'b0;
    base   = pcount;
    step();
    check_vec("t6_push0_pc", if_to_iq_pc, 32'h0);
    check_vec("t6_push0_inst", if_to_iq_inst, 32'h0010_0093);
    step();
    check_vec("t6_push1_pc", if_to_iq_pc, 32'h4);
    rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_vec("t6_frz_pc", if_to_ic_fetch_addr, 32'h8);
      check_vec("t6_frz_iqpc", if_to_iq_pc, 32'h4);
      check_vec("t6_frz_valid", {31'b0, if_to_iq_valid}, 32'h1);
    end
    rdy_in = 1'b1;
    step();
    check_vec("t6_push2_pc", if_to_iq_pc, 32'h8);
    step();
    check_vec("t6_push3_pc", if_to_iq_pc, 32'hC);
    @(negedge clk_in);
    #1;
    check_vec("t6_push_count", 32'(pcount - base), 32'h4);
    for (int k = 0; k < 4; k++) begin
      check_vec("t6_log_pc", plog[base + k], 32'(4 * k));
    end

    // PC wrap at the top of the address space
    br_redirect = 1'b1;
    br_target   = 32'hFFFF_FFFF;
    step();
    br_redirect = 1'b0;
    check_vec("t7_pc_top", if_to_ic_fetch_addr, 32'hFFFF_FFFC);
    check_vec("t7_redir_no_push", {31'b0, if_to_iq_valid}, 32'h0);
    step();
    check_vec("t7_push_pc", if_to_iq_pc, 32'hFFFF_FFFC);
    check_vec("t7_push_inst", if_to_iq_inst, 32'hC0FF_EE00);
    check_vec("t7_pc_wrap", if_to_ic_fetch_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
